// File: rtl/spi_slave_frame.sv
// ----------------------------------------------------------------------------
// Module : spi_slave_frame
// Desc   : SPI mode-0 slave, clk-oversampled, MSB-first WIDTH-bit frames.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_slave_frame #(
  parameter int WIDTH       = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid_pulse,
  output logic             frame_err
);

  localparam int c_cnt_w = $clog2(WIDTH + 2);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_END    = 2'd2
  } state_t;

  state_t r_state, w_next_state;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync, r_fresh;
  logic                   r_sclk_hist, r_cs_hist, r_armed, r_fall_pending;

  logic [WIDTH-1:0]   r_tx_shift, r_rx_shift, r_rx_data;
  logic [c_cnt_w-1:0] r_bit_cnt;
  logic               r_miso, r_miso_oe, r_rx_valid_pulse, r_frame_err;

  logic w_sclk_s, w_cs_s, w_mosi_s;
  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
  logic w_load, w_rx_en, w_tx_en, w_done_ok, w_done_err;

  // r_fresh marks synchroniser outputs that come from real post-reset samples;
  // cs_n must be seen high that way before a falling edge can start a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_fresh     <= '0;
      r_sclk_hist <= 1'b0;
      r_cs_hist   <= 1'b1;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_fresh     <= {r_fresh[SYNC_STAGES-2:0], 1'b1};
      r_sclk_hist <= w_sclk_s;
      r_cs_hist   <= w_cs_s;
      r_armed     <= r_armed | (r_fresh[SYNC_STAGES-1] & w_cs_s);
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_hist;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_hist;
  assign w_cs_rise   = w_cs_s & ~r_cs_hist;
  assign w_cs_fall   = ~w_cs_s & r_cs_hist & r_armed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_rx_en      = 1'b0;
    w_tx_en      = 1'b0;
    w_done_ok    = 1'b0;
    w_done_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall || r_fall_pending) begin
          w_load       = 1'b1;
          w_next_state = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_cs_rise) begin
          w_next_state = S_END;
        end else begin
          w_rx_en = w_sclk_rise;
          w_tx_en = w_sclk_fall;
        end
      end
      S_END: begin
        w_next_state = S_IDLE;
        if (r_bit_cnt == c_cnt_full) w_done_ok  = 1'b1;
        else                         w_done_err = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_shift       <= '0;
      r_rx_shift       <= '0;
      r_rx_data        <= '0;
      r_bit_cnt        <= '0;
      r_miso           <= 1'b0;
      r_miso_oe        <= 1'b0;
      r_rx_valid_pulse <= 1'b0;
      r_frame_err      <= 1'b0;
      r_fall_pending   <= 1'b0;
    end else begin
      r_rx_valid_pulse <= w_done_ok;
      r_frame_err      <= w_done_err;
      // A new frame starting during the single END cycle is replayed in IDLE.
      r_fall_pending   <= (r_state == S_END) & w_cs_fall;
      if (w_load) begin
        r_tx_shift <= tx_data;
        r_rx_shift <= '0;
        r_bit_cnt  <= '0;
        r_miso_oe  <= 1'b1;
        r_miso     <= tx_data[WIDTH-1];
      end
      if (w_rx_en) begin
        r_rx_shift <= {r_rx_shift[WIDTH-2:0], w_mosi_s};
        if (r_bit_cnt != c_cnt_max) r_bit_cnt <= r_bit_cnt + c_cnt_one;
      end
      if (w_tx_en) begin
        r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
        r_miso     <= r_tx_shift[WIDTH-2];
      end
      if (w_done_ok) r_rx_data <= r_rx_shift;
      if (w_done_ok || w_done_err) begin
        r_miso_oe <= 1'b0;
        r_miso    <= 1'b0;
      end
    end
  end

  assign miso           = r_miso;
  assign miso_oe        = r_miso_oe;
  assign rx_data        = r_rx_data;
  assign rx_valid_pulse = r_rx_valid_pulse;
  assign frame_err      = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_frame.sv
// ----------------------------------------------------------------------------
// Module : tb_spi_slave_frame
// Desc   : Directed bench for spi_slave_frame with an rx-word scoreboard.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_spi_slave_frame;

  localparam int WIDTH       = 64;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             reset, sclk, cs_n, mosi;
  logic             miso, miso_oe, rx_valid_pulse, frame_err;
  logic [WIDTH-1:0] tx_data, rx_data;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_err    = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] exp_word;

  spi_slave_frame #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk            (clk),
    .reset          (reset),
    .sclk           (sclk),
    .cs_n           (cs_n),
    .mosi           (mosi),
    .miso           (miso),
    .miso_oe        (miso_oe),
    .tx_data        (tx_data),
    .rx_data        (rx_data),
    .rx_valid_pulse (rx_valid_pulse),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rx_valid_pulse pops the next expected word.
  always @(posedge clk) begin
    #1;
    if (rx_valid_pulse === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_word = exp_q.pop_front();
        chk("rx_data_scoreboard", rx_data, exp_word);
      end
    end
    if (frame_err === 1'b1) n_err++;
    if (rx_valid_pulse === 1'b1 && frame_err === 1'b1) chk("pulses_together", 64'd1, 64'd0);
  end

  task automatic clock_bits(input logic [WIDTH-1:0] data, input int nbits, input int chg_bit);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < WIDTH) ? data[WIDTH-1-i] : 1'b0;
      repeat (5) @(negedge clk);
      cap  = {cap[WIDTH-2:0], miso};
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
      if (i == chg_bit) tx_data = '0;
    end
    mosi = 1'b0;
  endtask

  task automatic run_frame(input logic [WIDTH-1:0] data, input int nbits, input int chg_bit);
    @(negedge clk);
    cs_n = 1'b0;
    cap  = '0;
    repeat (10) @(negedge clk);
    chk("miso_oe_active", {63'd0, miso_oe}, 64'd1);
    clock_bits(data, nbits, chg_bit);
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
  endtask

  // Pulse must land on the (SYNC_STAGES+2)-th edge, counting the one that samples cs_n high as 1.
  task automatic check_end(input logic exp_valid);
    int   hit  = 0;
    logic kind = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (hit == 0 && (rx_valid_pulse === 1'b1 || frame_err === 1'b1)) begin
        hit  = k;
        kind = rx_valid_pulse;
      end
    end
    chk("end_latency", 64'(hit), 64'(SYNC_STAGES + 2));
    chk("end_kind", {63'd0, kind}, {63'd0, exp_valid});
    chk("miso_oe_after_end", {62'd0, miso_oe, miso}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_v, base_e;

    reset = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_data = '0; cap = '0;
    repeat (20) begin
      @(negedge clk);
      sclk = 1'($urandom); cs_n = 1'($urandom); mosi = 1'($urandom);
    end
    chk("in_reset_outs", {60'd0, miso, miso_oe, rx_valid_pulse, frame_err}, 64'd0);
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("reset_outs", {60'd0, miso, miso_oe, rx_valid_pulse, frame_err}, 64'd0);
    end
    chk("reset_rx_data", rx_data, 64'd0);
    chk("reset_no_pulses", 64'(n_valid + n_err), 64'd0);

    // Full frame
    tx_data = 64'hA5A5_0F0F_DEAD_BEEF;
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    base_v = n_valid; base_e = n_err;
    run_frame(64'h0123_4567_89AB_CDEF, 64, -1);
    chk("full_miso", cap, 64'hA5A5_0F0F_DEAD_BEEF);
    check_end(1'b1);
    chk("full_valid_cnt", 64'(n_valid - base_v), 64'd1);
    chk("full_err_cnt", 64'(n_err - base_e), 64'd0);
    chk("full_rx_data", rx_data, 64'h0123_4567_89AB_CDEF);

    // Short frame
    base_v = n_valid; base_e = n_err;
    run_frame(64'hFFFF_0000_FFFF_0000, 63, -1);
    check_end(1'b0);
    chk("short_err_cnt", 64'(n_err - base_e), 64'd1);
    chk("short_valid_cnt", 64'(n_valid - base_v), 64'd0);
    chk("short_rx_keep", rx_data, 64'h0123_4567_89AB_CDEF);

    // Long frame
    base_v = n_valid; base_e = n_err;
    run_frame(64'h1357_9BDF_2468_ACE0, 65, -1);
    check_end(1'b0);
    chk("long_err_cnt", 64'(n_err - base_e), 64'd1);
    chk("long_valid_cnt", 64'(n_valid - base_v), 64'd0);
    chk("long_rx_keep", rx_data, 64'h0123_4567_89AB_CDEF);

    // tx_data changed mid-frame, then a frame carrying the new value
    tx_data = 64'h1122_3344_5566_7788;
    exp_q.push_back(64'hCAFE_F00D_8BAD_F00D);
    run_frame(64'hCAFE_F00D_8BAD_F00D, 64, 10);
    chk("txchg_miso", cap, 64'h1122_3344_5566_7788);
    check_end(1'b1);
    exp_q.push_back(64'h0F1E_2D3C_4B5A_6978);
    run_frame(64'h0F1E_2D3C_4B5A_6978, 64, -1);
    chk("txchg_next_miso", cap, 64'd0);
    check_end(1'b1);

    // Reset mid-frame with cs_n held low throughout
    base_v = n_valid; base_e = n_err;
    tx_data = 64'h8000_0000_0000_0001;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (10) @(negedge clk);
    clock_bits(64'h5555_AAAA_5555_AAAA, 31, -1);
    reset = 1'b0;
    #1;
    chk("async_reset_oe", {62'd0, miso_oe, miso}, 64'd0);
    chk("async_reset_rx", rx_data, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    clock_bits(64'h3C3C_3C3C_3C3C_3C3C, 64, -1);
    chk("midrst_oe_idle", {63'd0, miso_oe}, 64'd0);
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_valid", 64'(n_valid - base_v), 64'd0);
    chk("midrst_no_err", 64'(n_err - base_e), 64'd0);
    chk("midrst_rx_data", rx_data, 64'd0);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    run_frame(64'hFFFF_FFFF_FFFF_FFFF, 64, -1);
    chk("midrst_clean_miso", cap, 64'h8000_0000_0000_0001);
    check_end(1'b1);
    chk("midrst_clean_rx", rx_data, 64'hFFFF_FFFF_FFFF_FFFF);

    // Back-to-back frames at the minimum cs_n high time
    base_v = n_valid; base_e = n_err;
    tx_data = 64'h0000_FFFF_0000_FFFF;
    exp_q.push_back(64'h0246_8ACE_1357_9BDF);
    run_frame(64'h0246_8ACE_1357_9BDF, 64, -1);
    chk("b2b_miso1", cap, 64'h0000_FFFF_0000_FFFF);
    tx_data = 64'h7777_8888_9999_AAAA;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    exp_q.push_back(64'hFEDC_BA98_7654_3210);
    run_frame(64'hFEDC_BA98_7654_3210, 64, -1);
    chk("b2b_miso2", cap, 64'h7777_8888_9999_AAAA);
    check_end(1'b1);
    chk("b2b_valid_cnt", 64'(n_valid - base_v), 64'd2);
    chk("b2b_err_cnt", 64'(n_err - base_e), 64'd0);
    chk("b2b_rx_last", rx_data, 64'hFEDC_BA98_7654_3210);

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
